// File: rtl/bp_io_host_responder_pkg.sv
// Shared types for the IO host responder: memory message layout, host register map and decode targets.
package bp_io_host_responder_pkg;

  localparam int paddr_width_gp   = 40;
  localparam int payload_width_gp = 8;

  localparam logic [19:0] putchar_base_addr_gp = 20'h0_1000;
  localparam logic [19:0] finish_base_addr_gp  = 20'h0_2000;
  localparam logic [19:0] cycle_base_addr_gp   = 20'h0_3000;
  localparam logic [19:0] scratch_base_addr_gp = 20'h0_4000;
  // Selects the 4 KiB device page within the decoded 20-bit host window
  localparam logic [19:0] host_decode_mask_gp  = 20'hF_F000;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } bp_mem_msg_e;

  typedef enum logic [2:0] {
    e_mem_size_1 = 3'd0,
    e_mem_size_2 = 3'd1,
    e_mem_size_4 = 3'd2,
    e_mem_size_8 = 3'd3
  } bp_mem_size_e;

  typedef struct packed {
    logic [63:0]                 data;
    logic [payload_width_gp-1:0] payload;
    bp_mem_size_e                size;
    logic [paddr_width_gp-1:0]   addr;
    bp_mem_msg_e                 msg_type;
  } bp_cce_mem_msg_s;

  localparam int mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

  typedef enum logic [2:0] {
    e_putchar,
    e_finish,
    e_cycle,
    e_scratch,
    e_unmapped
  } bp_host_target_e;

  function automatic logic [63:0] size_mask(input bp_mem_size_e size);
    case (size)
      e_mem_size_1: return 64'h0000_0000_0000_00FF;
      e_mem_size_2: return 64'h0000_0000_0000_FFFF;
      e_mem_size_4: return 64'h0000_0000_FFFF_FFFF;
      default:      return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/bp_io_host_responder_fifo.sv
// Small 1-read/1-write FIFO (bsg_fifo_1r1w_small style) holding putchar bytes.
// ready_o depends only on registered pointers, so a pop never frees a slot in the same cycle.
module bp_io_host_responder_fifo #(
  parameter int els_p   = 8,
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp:0]   wptr_r, rptr_r;
  logic                full, empty, push, pop;

  assign empty   = (wptr_r == rptr_r);
  assign full    = (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp])
                 && (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]);
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_r[rptr_r[ptr_w_lp-1:0]];
  assign push    = v_i & ~full;
  assign pop     = yumi_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r[ptr_w_lp-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push) wptr_r <= wptr_r + (ptr_w_lp+1)'(1);
      if (pop)  rptr_r <= rptr_r + (ptr_w_lp+1)'(1);
    end
  end

endmodule

// File: rtl/bp_io_host_responder.sv
// Synthesizable host responder for uncached IO commands: putchar, finish, cycle counter, scratch.
// Optional trace: define BP_IO_HOST_RESPONDER_TRACE_EN for a per-command $display (sim only).
//  state  | meaning
//  e_idle | waiting for a command (ready unless putchar and char FIFO full)
//  e_resp | response held valid until io_resp_yumi_i
module bp_io_host_responder
  import bp_io_host_responder_pkg::*;
#(
  parameter int num_core_p      = 1,
  parameter int char_fifo_els_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [mem_msg_width_gp-1:0] io_cmd_i,
  input  logic                        io_cmd_v_i,
  output logic                        io_cmd_ready_o,
  output logic [mem_msg_width_gp-1:0] io_resp_o,
  output logic                        io_resp_v_o,
  input  logic                        io_resp_yumi_i,
  output logic [7:0]                  char_o,
  output logic                        char_v_o,
  input  logic                        char_yumi_i,
  output logic [num_core_p-1:0]       program_finish_o,
  output logic                        decode_err_o
);

  typedef enum logic {e_idle, e_resp} state_e;

  state_e            state_r, state_n;
  bp_cce_mem_msg_s   cmd, resp_r;
  bp_host_target_e   target;
  logic [19:0]       addr20;
  logic [8:0]        fin_idx;
  logic              is_uc, is_wr, accept, char_ready, char_push, finish_rd;
  logic [63:0]       rd_data, cycle_r, scratch_r, wr_mask;
  logic [num_core_p-1:0] finish_r;
  logic              err_r;

  assign cmd     = io_cmd_i;
  assign addr20  = cmd.addr[19:0];
  assign fin_idx = cmd.addr[11:3];
  assign is_uc   = (cmd.msg_type == e_mem_msg_uc_rd) || (cmd.msg_type == e_mem_msg_uc_wr);
  assign is_wr   = (cmd.msg_type == e_mem_msg_uc_wr);
  assign wr_mask = size_mask(cmd.size);

  // Cached traffic and misaligned offsets fall through to e_unmapped
  always_comb begin
    target = e_unmapped;
    if (is_uc && (addr20[2:0] == 3'b000)) begin
      if (addr20 == putchar_base_addr_gp)
        target = e_putchar;
      else if ((addr20 & host_decode_mask_gp) == finish_base_addr_gp
               && 32'(fin_idx) < 32'(num_core_p))
        target = e_finish;
      else if (addr20 == cycle_base_addr_gp)
        target = e_cycle;
      else if (addr20 == scratch_base_addr_gp)
        target = e_scratch;
    end
  end

  always_comb begin
    finish_rd = 1'b0;
    for (int c = 0; c < num_core_p; c++)
      if (fin_idx == 9'(c)) finish_rd = finish_r[c];
    rd_data = '0;
    if (!is_wr) begin
      case (target)
        e_finish:  rd_data = {63'b0, finish_rd};
        e_cycle:   rd_data = cycle_r;
        e_scratch: rd_data = scratch_r;
        default:   rd_data = '0;
      endcase
    end
  end

  assign io_cmd_ready_o = reset_n_i && (state_r == e_idle)
                          && !((target == e_putchar) && !char_ready);
  assign accept    = io_cmd_v_i & io_cmd_ready_o;
  assign char_push = accept & is_wr & (target == e_putchar);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycle_r   <= '0;
      scratch_r <= '0;
      finish_r  <= '0;
      err_r     <= 1'b0;
      resp_r    <= '0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      if (accept) begin
        resp_r <= {rd_data, cmd.payload, cmd.size, cmd.addr, cmd.msg_type};
        if (target == e_unmapped) err_r <= 1'b1;
        if (is_wr && target == e_scratch)
          scratch_r <= (scratch_r & ~wr_mask) | (cmd.data & wr_mask);
        if (is_wr && target == e_finish)
          for (int c = 0; c < num_core_p; c++)
            if (fin_idx == 9'(c)) finish_r[c] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:  if (accept)         state_n = e_resp;
      e_resp:  if (io_resp_yumi_i) state_n = e_idle;
      default:                     state_n = e_idle;
    endcase
  end

  assign io_resp_v_o      = (state_r == e_resp);
  assign io_resp_o        = resp_r;
  assign program_finish_o = finish_r;
  assign decode_err_o     = err_r;

  bp_io_host_responder_fifo #(
    .els_p   (char_fifo_els_p),
    .width_p (8)
  ) char_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (char_push),
    .data_i    (cmd.data[7:0]),
    .ready_o   (char_ready),
    .v_o       (char_v_o),
    .data_o    (char_o),
    .yumi_i    (char_yumi_i)
  );

`ifdef BP_IO_HOST_RESPONDER_TRACE_EN
`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (accept) begin
      $display("%t io_cmd type=%0d addr=%h data=%h", $time, cmd.msg_type, cmd.addr, cmd.data);
      if (is_wr && target == e_finish) $display("[CORE %0d FINISH]", fin_idx);
    end
  end
`endif
`else
  // no trace logic in this build
`endif

endmodule
